// File: rtl/shift_unit.sv
// shift_unit: two-stage pipelined barrel shifter with a valid/ready handshake.
// Ops: SLL, SRL, SRA and, when SHIFT_UNIT_ROTATE_EN is defined, ROR.
// Without SHIFT_UNIT_ROTATE_EN, op 11 passes the operand through and flags
// out_illegal. Stage A applies the coarse part of the shift amount, stage B
// (the output register) applies the fine part.
module shift_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_illegal,
    output logic             busy
);

    // Split point of the shift amount: [SHW-1:H] is coarse, [H-1:0] is fine.
    localparam int H = SHW / 2;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // Stage A registers
    logic             a_valid_q, a_valid_d;
    logic [WIDTH-1:0] a_data_q,  a_data_d;
    logic [H-1:0]     a_fine_q,  a_fine_d;
    logic [1:0]       a_op_q,    a_op_d;
    logic [TAG_W-1:0] a_tag_q,   a_tag_d;
    logic             a_sign_q,  a_sign_d;

    // Stage B (output) registers
    logic             out_valid_q,   out_valid_d;
    logic [WIDTH-1:0] out_data_q,    out_data_d;
    logic [TAG_W-1:0] out_tag_q,     out_tag_d;
    logic             out_zero_q,    out_zero_d;
    logic             out_illegal_q, out_illegal_d;

    // Holds in_ready low during reset and for the release edge itself.
    logic             rdy_en_q, rdy_en_d;

    logic             adv_a;
    logic             adv_b;
    logic             accept;

    logic [SHW-1:0]     coarse_amt;
    logic [WIDTH-1:0]   a_part;
    logic [WIDTH-1:0]   b_result;
    logic [2*WIDTH-1:0] sra_wide;
`ifdef SHIFT_UNIT_ROTATE_EN
    logic [2*WIDTH-1:0] ror_a_wide;
    logic [2*WIDTH-1:0] ror_b_wide;
`endif

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // The producer holds valid and payload until it sees ready; ready never
    // depends on valid. A stage advances when it is empty or its consumer
    // takes its contents this cycle, so out_ready reaches in_ready
    // combinationally and a full pipeline still moves one op per cycle.
    always_comb begin
        adv_b    = !out_valid_q || out_ready;
        adv_a    = !a_valid_q || adv_b;
        in_ready = adv_a && rdy_en_q;
        accept   = in_valid && in_ready;
    end

    // Stage A datapath: coarse shift of the incoming operand.
    always_comb begin
        coarse_amt = {in_amt[SHW-1:H], {H{1'b0}}};
`ifdef SHIFT_UNIT_ROTATE_EN
        ror_a_wide = {in_data, in_data} >> coarse_amt;
`endif
        case (in_op)
            OP_SLL:  a_part = in_data << coarse_amt;
            OP_SRL:  a_part = in_data >> coarse_amt;
            OP_SRA:  a_part = $signed(in_data) >>> coarse_amt;
`ifdef SHIFT_UNIT_ROTATE_EN
            OP_ROR:  a_part = ror_a_wide[WIDTH-1:0];
`else
            OP_ROR:  a_part = in_data;
`endif
            default: a_part = in_data;
        endcase
    end

    // Stage B datapath: fine shift, filling SRA from the stored original sign.
    always_comb begin
        sra_wide = {{WIDTH{a_sign_q}}, a_data_q} >> a_fine_q;
`ifdef SHIFT_UNIT_ROTATE_EN
        ror_b_wide = {a_data_q, a_data_q} >> a_fine_q;
`endif
        case (a_op_q)
            OP_SLL:  b_result = a_data_q << a_fine_q;
            OP_SRL:  b_result = a_data_q >> a_fine_q;
            OP_SRA:  b_result = sra_wide[WIDTH-1:0];
`ifdef SHIFT_UNIT_ROTATE_EN
            OP_ROR:  b_result = ror_b_wide[WIDTH-1:0];
`else
            OP_ROR:  b_result = a_data_q;
`endif
            default: b_result = a_data_q;
        endcase
    end

    // Next-state logic for both pipeline stages; payloads load only on advance.
    always_comb begin
        rdy_en_d      = 1'b1;
        a_valid_d     = a_valid_q;
        a_data_d      = a_data_q;
        a_fine_d      = a_fine_q;
        a_op_d        = a_op_q;
        a_tag_d       = a_tag_q;
        a_sign_d      = a_sign_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_tag_d     = out_tag_q;
        out_zero_d    = out_zero_q;
        out_illegal_d = out_illegal_q;

        if (adv_a) begin
            a_valid_d = accept;
        end
        if (accept) begin
            a_data_d = a_part;
            a_fine_d = in_amt[H-1:0];
            a_op_d   = in_op;
            a_tag_d  = in_tag;
            a_sign_d = in_data[WIDTH-1];
        end

        if (adv_b) begin
            out_valid_d = a_valid_q;
            if (a_valid_q) begin
                out_data_d = b_result;
                out_tag_d  = a_tag_q;
                out_zero_d = (b_result == '0);
`ifdef SHIFT_UNIT_ROTATE_EN
                out_illegal_d = 1'b0;
`else
                out_illegal_d = (a_op_q == OP_ROR);
`endif
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdy_en_q      <= 1'b0;
            a_valid_q     <= 1'b0;
            a_data_q      <= '0;
            a_fine_q      <= '0;
            a_op_q        <= '0;
            a_tag_q       <= '0;
            a_sign_q      <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_tag_q     <= '0;
            out_zero_q    <= 1'b0;
            out_illegal_q <= 1'b0;
        end else begin
            rdy_en_q      <= rdy_en_d;
            a_valid_q     <= a_valid_d;
            a_data_q      <= a_data_d;
            a_fine_q      <= a_fine_d;
            a_op_q        <= a_op_d;
            a_tag_q       <= a_tag_d;
            a_sign_q      <= a_sign_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_tag_q     <= out_tag_d;
            out_zero_q    <= out_zero_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    // Output drives
    always_comb begin
        out_valid   = out_valid_q;
        out_data    = out_data_q;
        out_tag     = out_tag_q;
        out_zero    = out_zero_q;
        out_illegal = out_illegal_q;
        busy        = a_valid_q | out_valid_q;
    end

endmodule

// File: tb/tb_shift_unit.sv
// tb_shift_unit: self-checking bench for shift_unit (WIDTH = 32, TAG_W = 4).
// Expected results come from a reference shift model and are queued when a
// request is accepted, then compared in order as results leave the unit.
module tb_shift_unit;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;
    localparam int SHW   = 5;
    localparam int EW    = 1 + TAG_W + WIDTH;

    logic             i_clk;
    logic             i_rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;
    logic             out_illegal;
    logic             busy;

    // Expected entries: {illegal, tag, data}
    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;

    shift_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_amt     (in_amt),
        .in_op      (in_op),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .out_zero   (out_zero),
        .out_illegal(out_illegal),
        .busy       (busy)
    );

    // Clock
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model computed from the full shift amount.
    function automatic logic [WIDTH-1:0] model_shift(input logic [WIDTH-1:0] d,
                                                     input logic [SHW-1:0] a,
                                                     input logic [1:0] op);
        logic [WIDTH-1:0] r;
        case (op)
            2'b00:   r = d << a;
            2'b01:   r = d >> a;
            2'b10:   r = $signed(d) >>> a;
`ifdef SHIFT_UNIT_ROTATE_EN
            default: r = (d >> a) | (d << (WIDTH - int'(a)));
`else
            default: r = d;
`endif
        endcase
        return r;
    endfunction

    function automatic logic model_illegal(input logic [1:0] op);
`ifdef SHIFT_UNIT_ROTATE_EN
        return 1'b0;
`else
        return (op == 2'b11);
`endif
    endfunction

    task automatic push_exp(input logic [WIDTH-1:0] d, input logic [SHW-1:0] a,
                            input logic [1:0] op, input logic [TAG_W-1:0] tag);
        exp_q.push_back({model_illegal(op), tag, model_shift(d, a, op)});
    endtask

    // Driver: called at posedge+1; returns at posedge+1 right after the accept edge.
    task automatic send(input logic [WIDTH-1:0] d, input logic [SHW-1:0] a,
                        input logic [1:0] op, input logic [TAG_W-1:0] tag);
        int waited;
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_op    = op;
        in_tag   = tag;
        waited   = 0;
        @(negedge i_clk);
        while (!in_ready && waited < 200) begin
            @(negedge i_clk);
            waited++;
        end
        if (!in_ready) begin
            check_eq("send_timeout", 64'(in_ready), 64'd1);
        end else begin
            push_exp(d, a, op, tag);
        end
        @(posedge i_clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Open the output and wait, bounded, until every queued result has left.
    task automatic wait_drain(input string name);
        int cyc;
        out_ready = 1'b1;
        cyc = 0;
        while ((exp_q.size() != 0 || busy) && cyc < 100) begin
            @(posedge i_clk);
            #1;
            cyc++;
        end
        check_eq(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Random traffic with random backpressure, one decision per cycle.
    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom();
            in_amt    = SHW'($urandom_range(0, 31));
            in_op     = 2'($urandom_range(0, 3));
            in_tag    = TAG_W'($urandom_range(0, 15));
            @(negedge i_clk);
            if (in_valid && in_ready) push_exp(in_data, in_amt, in_op, in_tag);
            @(posedge i_clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Scoreboard: compare every delivered result against the queue head.
    always @(negedge i_clk) begin
        logic [EW-1:0] e;
        if (i_rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                n_out++;
                check_eq("sb_data",    64'(out_data),    64'(e[WIDTH-1:0]));
                check_eq("sb_tag",     64'(out_tag),     64'(e[WIDTH+TAG_W-1:WIDTH]));
                check_eq("sb_zero",    64'(out_zero),    64'(e[WIDTH-1:0] == '0));
                check_eq("sb_illegal", 64'(out_illegal), 64'(e[EW-1]));
            end
        end
    end

    initial begin
        int n_before;
        logic [WIDTH-1:0] held_data;

        i_rst_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_op     = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check_eq("rst_out_valid",   64'(out_valid),   64'd0);
        check_eq("rst_busy",        64'(busy),        64'd0);
        check_eq("rst_in_ready",    64'(in_ready),    64'd0);
        check_eq("rst_out_data",    64'(out_data),    64'd0);
        check_eq("rst_out_tag",     64'(out_tag),     64'd0);
        check_eq("rst_out_zero",    64'(out_zero),    64'd0);
        check_eq("rst_out_illegal", 64'(out_illegal), 64'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        check_eq("post_rst_ready", 64'(in_ready), 64'd1);

        // SLL 1 by 31: two-edge latency
        send(32'h0000_0001, 5'd31, 2'b00, 4'd3);
        check_eq("lat_stage_a", 64'(out_valid), 64'd0);
        check_eq("lat_busy",    64'(busy),      64'd1);
        @(posedge i_clk);
        #1;
        check_eq("lat_out_valid", 64'(out_valid), 64'd1);
        check_eq("lat_out_data",  64'(out_data),  64'h8000_0000);
        check_eq("lat_out_tag",   64'(out_tag),   64'd3);
        wait_drain("drain_sll");

        // SRL / SRA / SLL back-to-back, one result per cycle
        send(32'h8000_0000, 5'd4, 2'b01, 4'd1);
        send(32'h8000_0000, 5'd4, 2'b10, 4'd2);
        check_eq("b2b_first_tag",  64'(out_tag),  64'd1);
        check_eq("b2b_first_data", 64'(out_data), 64'h0800_0000);
        send(32'h8000_0000, 5'd1, 2'b00, 4'd4);
        check_eq("b2b_second_tag",  64'(out_tag),  64'd2);
        check_eq("b2b_second_data", 64'(out_data), 64'hF800_0000);
        @(posedge i_clk);
        #1;
        check_eq("b2b_zero_data", 64'(out_data), 64'd0);
        check_eq("b2b_zero_flag", 64'(out_zero), 64'd1);
        wait_drain("drain_b2b");

        // Amount 0 passes the operand for every shift op
        send(32'hA5A5_A5A5, 5'd0, 2'b00, 4'd5);
        send(32'hA5A5_A5A5, 5'd0, 2'b01, 4'd6);
        send(32'hA5A5_A5A5, 5'd0, 2'b10, 4'd7);
        wait_drain("drain_amt0");

        // Op 11: rotate or illegal pass-through depending on build
        send(32'h0000_00F1, 5'd4, 2'b11, 4'd8);
        @(posedge i_clk);
        #1;
`ifdef SHIFT_UNIT_ROTATE_EN
        check_eq("op11_data",    64'(out_data),    64'h1000_000F);
        check_eq("op11_illegal", 64'(out_illegal), 64'd0);
`else
        check_eq("op11_data",    64'(out_data),    64'h0000_00F1);
        check_eq("op11_illegal", 64'(out_illegal), 64'd1);
`endif
        wait_drain("drain_op11");

        // Backpressure: tags 1, 2 accepted, tag 3 refused until release
        n_before  = n_out;
        out_ready = 1'b0;
        send(32'h0000_0011, 5'd0, 2'b00, 4'd1);
        send(32'h0000_0022, 5'd0, 2'b00, 4'd2);
        in_valid = 1'b1;
        in_data  = 32'h0000_0033;
        in_amt   = 5'd0;
        in_op    = 2'b00;
        in_tag   = 4'd3;
        @(negedge i_clk);
        check_eq("bp_full_ready", 64'(in_ready),  64'd0);
        check_eq("bp_full_busy",  64'(busy),      64'd1);
        check_eq("bp_head_tag",   64'(out_tag),   64'd1);
        held_data = out_data;
        repeat (2) @(negedge i_clk);
        check_eq("bp_hold_valid", 64'(out_valid), 64'd1);
        check_eq("bp_hold_data",  64'(out_data),  64'(held_data));
        check_eq("bp_hold_tag",   64'(out_tag),   64'd1);
        check_eq("bp_still_full", 64'(in_ready),  64'd0);
        @(posedge i_clk);
        #1;
        out_ready = 1'b1;
        @(negedge i_clk);
        check_eq("bp_release_ready", 64'(in_ready), 64'd1);
        if (in_ready) push_exp(32'h0000_0033, 5'd0, 2'b00, 4'd3);
        @(posedge i_clk);
        #1;
        in_valid = 1'b0;
        wait_drain("drain_bp");
        check_eq("bp_count", 64'(n_out - n_before), 64'd3);

        // Reset with two operations in flight
        out_ready = 1'b0;
        send(32'h1234_5678, 5'd3, 2'b00, 4'd9);
        send(32'h8765_4321, 5'd7, 2'b10, 4'd10);
        i_rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("mid_rst_busy",      64'(busy),      64'd0);
        check_eq("mid_rst_in_ready",  64'(in_ready),  64'd0);
        exp_q.delete();
        @(negedge i_clk);
        check_eq("mid_rst_hold_ready", 64'(in_ready), 64'd0);
        @(posedge i_clk);
        #1;
        i_rst_n   = 1'b1;
        out_ready = 1'b1;
        @(posedge i_clk);
        #1;
        check_eq("rel_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            check_eq("rel_no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge i_clk);
        #1;
        n_before = n_out;
        send(32'h0000_00FF, 5'd8, 2'b00, 4'd11);
        wait_drain("drain_rst");
        check_eq("rel_new_result", 64'(n_out - n_before), 64'd1);

        // Random traffic with random backpressure
        rand_phase(300);
        wait_drain("drain_rand");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
